// File: rtl/sobel_window_shifter.sv
// WIN x WIN pixel window for Sobel filtering with left/right/down shifts for snake traversal.
// Vacated slots are refilled from the pixel read stream, tracked by an explicit fill pointer.
module sobel_window_shifter #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned WIN    = 3,
   parameter int unsigned CNT_W  = $clog2(WIN*WIN+1)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start_shift,
   input  logic [1:0]                shift_direc,
   input  logic                      start_read,
   input  logic [DATA_W-1:0]         data_r,
   output logic [WIN*WIN*DATA_W-1:0] window,
   output logic                      window_valid,
   output logic                      read_done,
   output logic                      shift_done,
   output logic [CNT_W-1:0]          fill_remaining,
   output logic                      err
);

   localparam int unsigned NPIX = WIN * WIN;

   typedef enum logic [1:0] {StFullFill, StEdgeFill, StReady} state_e;

   state_e            state_q, state_d;
   logic [DATA_W-1:0] win_q [NPIX];
   logic [DATA_W-1:0] win_d [NPIX];
   logic [CNT_W-1:0]  ptr_q, ptr_d;
   logic [CNT_W-1:0]  fill_q, fill_d;
   logic              col_step_q, col_step_d;
   logic              valid_q, valid_d;
   logic              read_done_q, read_done_d;
   logic              shift_done_q, shift_done_d;
   logic              err_q, err_d;

   always_comb begin
      state_d      = state_q;
      win_d        = win_q;
      ptr_d        = ptr_q;
      fill_d       = fill_q;
      col_step_d   = col_step_q;
      valid_d      = valid_q;
      read_done_d  = 1'b0;
      shift_done_d = 1'b0;
      err_d        = 1'b0;
      unique case (state_q)
         StFullFill, StEdgeFill: begin
            if (start_read) begin
               for (int i = 0; i < NPIX; i++) begin
                  if (ptr_q == CNT_W'(i)) win_d[i] = data_r;
               end
               // Column refills walk down a column, so the pointer steps by a whole row.
               ptr_d       = ptr_q + (col_step_q ? CNT_W'(WIN) : CNT_W'(1));
               fill_d      = fill_q - CNT_W'(1);
               read_done_d = 1'b1;
               if (fill_q == CNT_W'(1)) begin
                  state_d = StReady;
                  valid_d = 1'b1;
               end
            end
            if (start_shift) err_d = 1'b1;
         end
         StReady: begin
            if (start_shift && shift_direc != 2'b00) begin
               shift_done_d = 1'b1;
               valid_d      = 1'b0;
               fill_d       = CNT_W'(WIN);
               state_d      = StEdgeFill;
               unique case (shift_direc)
                  2'b01: begin
                     for (int r = 0; r < WIN; r++) begin
                        for (int c = 0; c < WIN - 1; c++) win_d[r*WIN+c] = win_q[r*WIN+c+1];
                        win_d[r*WIN+WIN-1] = '0;
                     end
                     ptr_d      = CNT_W'(WIN - 1);
                     col_step_d = 1'b1;
                  end
                  2'b10: begin
                     for (int r = 0; r < WIN; r++) begin
                        for (int c = 1; c < WIN; c++) win_d[r*WIN+c] = win_q[r*WIN+c-1];
                        win_d[r*WIN] = '0;
                     end
                     ptr_d      = '0;
                     col_step_d = 1'b1;
                  end
                  2'b11: begin
                     for (int r = 1; r < WIN; r++) begin
                        for (int c = 0; c < WIN; c++) win_d[r*WIN+c] = win_q[(r-1)*WIN+c];
                     end
                     for (int c = 0; c < WIN; c++) win_d[c] = '0;
                     ptr_d      = '0;
                     col_step_d = 1'b0;
                  end
                  default: ;
               endcase
            end
            // A read in READY is always dropped, even alongside a legal shift.
            err_d = (start_shift && shift_direc == 2'b00) || start_read;
         end
         default: state_d = StFullFill;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StFullFill;
         for (int i = 0; i < NPIX; i++) win_q[i] <= '0;
         ptr_q        <= '0;
         fill_q       <= CNT_W'(NPIX);
         col_step_q   <= 1'b0;
         valid_q      <= 1'b0;
         read_done_q  <= 1'b0;
         shift_done_q <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         win_q        <= win_d;
         ptr_q        <= ptr_d;
         fill_q       <= fill_d;
         col_step_q   <= col_step_d;
         valid_q      <= valid_d;
         read_done_q  <= read_done_d;
         shift_done_q <= shift_done_d;
         err_q        <= err_d;
      end
   end

   for (genvar gi = 0; gi < NPIX; gi++) begin : g_window
      assign window[gi*DATA_W +: DATA_W] = win_q[gi];
   end

   assign window_valid   = valid_q;
   assign read_done      = read_done_q;
   assign shift_done     = shift_done_q;
   assign fill_remaining = fill_q;
   assign err            = err_q;

endmodule

// File: tb/tb_sobel_window_shifter.sv
// Bench for sobel_window_shifter: directed scenarios plus random traffic against a
// queue-based model of pending fill slots.
module tb_sobel_window_shifter;

   localparam int DW = 8;
   localparam int W  = 3;
   localparam int N  = W * W;
   localparam int CW = $clog2(N + 1);

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start_shift = 1'b0;
   logic [1:0]        shift_direc = 2'b00;
   logic              start_read = 1'b0;
   logic [DW-1:0]     data_r = '0;
   logic [N*DW-1:0]   window;
   logic              window_valid;
   logic              read_done;
   logic              shift_done;
   logic [CW-1:0]     fill_remaining;
   logic              err;

   int checks = 0;
   int errors = 0;

   // Reference model: pixel array plus queue of slots still to be filled, in fill order.
   int m_win [N];
   int m_q [$];
   bit m_rd, m_sd, m_err;

   sobel_window_shifter #(.DATA_W(DW), .WIN(W)) dut (
      .clk            (clk),
      .rst            (rst),
      .start_shift    (start_shift),
      .shift_direc    (shift_direc),
      .start_read     (start_read),
      .data_r         (data_r),
      .window         (window),
      .window_valid   (window_valid),
      .read_done      (read_done),
      .shift_done     (shift_done),
      .fill_remaining (fill_remaining),
      .err            (err)
   );

   always #5 clk = ~clk;

   function automatic logic [N*DW-1:0] exp_window();
      logic [N*DW-1:0] v;
      for (int i = 0; i < N; i++) v[i*DW +: DW] = DW'(m_win[i]);
      return v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) m_win[i] = 0;
      m_q.delete();
      for (int i = 0; i < N; i++) m_q.push_back(i);
      m_rd = 0; m_sd = 0; m_err = 0;
   endtask

   task automatic model_step(input bit sr, input bit ss, input logic [1:0] dir, input int d);
      int old [N];
      m_rd = 0; m_sd = 0; m_err = 0;
      if (m_q.size() == 0) begin
         if (ss) begin
            if (dir == 2'b00) m_err = 1;
            else begin
               old = m_win;
               for (int r = 0; r < W; r++) begin
                  for (int c = 0; c < W; c++) begin
                     if (dir == 2'b01)      m_win[r*W+c] = (c < W-1) ? old[r*W+c+1] : 0;
                     else if (dir == 2'b10) m_win[r*W+c] = (c > 0) ? old[r*W+c-1] : 0;
                     else                   m_win[r*W+c] = (r > 0) ? old[(r-1)*W+c] : 0;
                  end
               end
               for (int k = 0; k < W; k++) begin
                  if (dir == 2'b01)      m_q.push_back(k*W + W - 1);
                  else if (dir == 2'b10) m_q.push_back(k*W);
                  else                   m_q.push_back(k);
               end
               m_sd = 1;
            end
         end
         if (sr) m_err = 1;
      end else begin
         if (sr) begin
            m_win[m_q.pop_front()] = d;
            m_rd = 1;
         end
         if (ss) m_err = 1;
      end
   endtask

   task automatic cycle(input bit sr, input bit ss, input logic [1:0] dir, input int d);
      start_read  = sr;
      start_shift = ss;
      shift_direc = dir;
      data_r      = DW'(d);
      @(posedge clk);
      model_step(sr, ss, dir, d);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; start_read = 1'b0; start_shift = 1'b0; shift_direc = 2'b00;
      @(posedge clk);
      model_reset();
      #1;
      rst = 1'b0;
   endtask

   task automatic fill_1_to_9();
      do_reset();
      for (int i = 1; i <= N; i++) cycle(1, 0, 2'b00, i);
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (window !== '0) begin errors++; $display("FAIL reset_window got %h exp 0", window); end
      checks++; if (window_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", window_valid); end
      checks++; if (fill_remaining !== CW'(N)) begin errors++; $display("FAIL reset_fill got %0d exp %0d", fill_remaining, N); end
      checks++; if ({read_done, shift_done, err} !== 3'b000) begin errors++; $display("FAIL reset_pulses got %b exp 000", {read_done, shift_done, err}); end
   endtask

   task automatic test_full_fill();
      do_reset();
      for (int i = 1; i <= N; i++) begin
         cycle(1, 0, 2'b00, i);
         checks++; if (read_done !== 1'b1) begin errors++; $display("FAIL fill_read_done[%0d] got %b exp 1", i, read_done); end
         checks++; if (fill_remaining !== CW'(N - i)) begin errors++; $display("FAIL fill_remaining[%0d] got %0d exp %0d", i, fill_remaining, N - i); end
         checks++; if (window_valid !== (i == N)) begin errors++; $display("FAIL fill_valid[%0d] got %b exp %b", i, window_valid, i == N); end
      end
      checks++; if (window !== 72'h090807060504030201) begin errors++; $display("FAIL fill_window got %h exp 090807060504030201", window); end
   endtask

   task automatic test_shift_left();
      fill_1_to_9();
      cycle(0, 1, 2'b01, 0);
      checks++; if (shift_done !== 1'b1 || window_valid !== 1'b0) begin errors++; $display("FAIL left_pulse got sd=%b v=%b exp sd=1 v=0", shift_done, window_valid); end
      checks++; if (window !== 72'h000908000605000302) begin errors++; $display("FAIL left_shifted got %h exp 000908000605000302", window); end
      checks++; if (fill_remaining !== CW'(W)) begin errors++; $display("FAIL left_fill got %0d exp %0d", fill_remaining, W); end
      cycle(1, 0, 2'b00, 10);
      cycle(1, 0, 2'b00, 11);
      cycle(1, 0, 2'b00, 12);
      checks++; if (window !== 72'h0c09080b06050a0302) begin errors++; $display("FAIL left_refill got %h exp 0c09080b06050a0302", window); end
      checks++; if (window_valid !== 1'b1 || read_done !== 1'b1) begin errors++; $display("FAIL left_valid got v=%b rd=%b exp 1 1", window_valid, read_done); end
   endtask

   task automatic test_shift_down();
      fill_1_to_9();
      cycle(0, 1, 2'b11, 0);
      cycle(1, 0, 2'b00, 0);
      cycle(1, 0, 2'b00, 0);
      checks++; if (window_valid !== 1'b0 || fill_remaining !== CW'(1)) begin errors++; $display("FAIL down_partial got v=%b fill=%0d exp v=0 fill=1", window_valid, fill_remaining); end
      cycle(1, 0, 2'b00, 0);
      checks++; if (window !== 72'h060504030201000000) begin errors++; $display("FAIL down_window got %h exp 060504030201000000", window); end
      checks++; if (window_valid !== 1'b1 || fill_remaining !== '0) begin errors++; $display("FAIL down_valid got v=%b fill=%0d exp v=1 fill=0", window_valid, fill_remaining); end
   endtask

   task automatic test_illegal();
      do_reset();
      for (int i = 1; i <= 4; i++) cycle(1, 0, 2'b00, i);
      cycle(0, 1, 2'b01, 0);
      checks++; if (err !== 1'b1 || shift_done !== 1'b0) begin errors++; $display("FAIL ill_shift_in_fill got err=%b sd=%b exp 1 0", err, shift_done); end
      checks++; if (fill_remaining !== CW'(5)) begin errors++; $display("FAIL ill_fill_kept got %0d exp 5", fill_remaining); end
      for (int i = 5; i <= N; i++) cycle(1, 0, 2'b00, i);
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL ill_err_drop got %b exp 0", err); end
      cycle(0, 1, 2'b00, 0);
      checks++; if (err !== 1'b1 || window !== 72'h090807060504030201 || window_valid !== 1'b1) begin errors++; $display("FAIL ill_dir00 got err=%b v=%b win=%h", err, window_valid, window); end
      cycle(1, 0, 2'b00, 8'h55);
      checks++; if (err !== 1'b1 || read_done !== 1'b0 || window !== 72'h090807060504030201) begin errors++; $display("FAIL ill_read_ready got err=%b rd=%b win=%h", err, read_done, window); end
   endtask

   task automatic test_simultaneous();
      fill_1_to_9();
      cycle(1, 1, 2'b10, 8'h77);
      checks++; if (window !== 72'h080700050400020100) begin errors++; $display("FAIL simul_window got %h exp 080700050400020100", window); end
      checks++; if ({shift_done, err, read_done} !== 3'b110) begin errors++; $display("FAIL simul_pulses got sd,err,rd=%b exp 110", {shift_done, err, read_done}); end
   endtask

   task automatic test_reset_midfill();
      fill_1_to_9();
      cycle(0, 1, 2'b01, 0);
      cycle(1, 0, 2'b00, 33);
      cycle(1, 0, 2'b00, 44);
      do_reset();
      checks++; if (window !== '0 || window_valid !== 1'b0) begin errors++; $display("FAIL rstmid_window got v=%b win=%h exp 0", window_valid, window); end
      checks++; if (fill_remaining !== CW'(N) || {read_done, shift_done, err} !== 3'b000) begin errors++; $display("FAIL rstmid_state got fill=%0d pulses=%b exp 9 000", fill_remaining, {read_done, shift_done, err}); end
   endtask

   task automatic test_random();
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 199) == 0) do_reset();
         else cycle($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 2,
                    2'($urandom_range(0, 3)), int'($urandom_range(0, 255)));
         checks++; if (window !== exp_window()) begin errors++; $display("FAIL rnd_window[%0d] got %h exp %h", n, window, exp_window()); end
         checks++; if (window_valid !== (m_q.size() == 0)) begin errors++; $display("FAIL rnd_valid[%0d] got %b exp %b", n, window_valid, m_q.size() == 0); end
         checks++; if (fill_remaining !== CW'(m_q.size())) begin errors++; $display("FAIL rnd_fill[%0d] got %0d exp %0d", n, fill_remaining, m_q.size()); end
         checks++; if ({read_done, shift_done, err} !== {m_rd, m_sd, m_err}) begin errors++; $display("FAIL rnd_pulses[%0d] got %b exp %b", n, {read_done, shift_done, err}, {m_rd, m_sd, m_err}); end
      end
   endtask

   initial begin
      test_reset();
      test_full_fill();
      test_shift_left();
      test_shift_down();
      test_illegal();
      test_simultaneous();
      test_reset_midfill();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sobel_window_shifter.md
# sobel_window_shifter

Parametrised, clocked successor to the combinational 3x3 Sobel window buffer. It holds a WIN x WIN pixel window and supports left, right and down shifts for snake-order image traversal. After each shift it refills the vacated column or row from the pixel read stream. Vacated slots are tracked with an explicit fill pointer, so zero-valued pixels are legal data. The block sits between the pixel read/address controller and the Sobel gradient calculator; the calculator consumes the window only while `window_valid` is high.

## Interface
- `DATA_W`, 8, pixel width in bits
- `WIN`, 3, window side length (WIN >= 2)
- `CNT_W`, $clog2(WIN*WIN+1), width of fill counter (derived)

- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, synchronous, active-high
- `start_shift`  in  1  request a shift, sampled each cycle
- `shift_direc`  in  2  01 left, 10 right, 11 down, 00 illegal
- `start_read`  in  1  `data_r` holds the next pixel for the current fill slot
- `data_r`  in  DATA_W  pixel data
- `window`  out  WIN*WIN*DATA_W  pixel (r,c) at bits [(r*WIN+c)*DATA_W +: DATA_W]; r=0 is the top row, c=0 is the left column
- `window_valid`  out  1  all WIN*WIN slots hold real pixels
- `read_done`  out  1  one-cycle pulse: a pixel was written
- `shift_done`  out  1  one-cycle pulse: a shift was performed
- `fill_remaining`  out  CNT_W  pixels still needed before `window_valid`
- `err`  out  1  one-cycle pulse: a request was ignored

## Operation
- States:
  - FULL_FILL: after reset; fills all WIN*WIN slots.
  - EDGE_FILL: after a shift; fills the WIN vacated slots.
  - READY: window complete.
- Reset:
  - `window`=0, `window_valid`=0, `read_done`=0, `shift_done`=0, `err`=0.
  - `fill_remaining`=WIN*WIN, state FULL_FILL, fill pointer at slot (0,0).
- FULL_FILL fill order: row-major, (0,0),(0,1),…,(WIN-1,WIN-1).
- Accepted read (FULL_FILL or EDGE_FILL with `start_read`=1):
  - write `data_r` to the slot at the pointer
  - advance the pointer
  - decrement `fill_remaining`
  - pulse `read_done`
- When `fill_remaining` reaches 0: go to READY and set `window_valid`=1.
- In READY with `start_shift`=1:
  - Left (01): column c takes column c+1; column WIN-1 is zeroed. Fill order is (0,WIN-1)…(WIN-1,WIN-1), top to bottom.
  - Right (10): column c takes column c-1; column 0 is zeroed. Fill order is (0,0)…(WIN-1,0), top to bottom.
  - Down (11): row r takes row r-1; row 0 is zeroed. Fill order is (0,0)…(0,WIN-1), left to right.
  - After any legal shift: `fill_remaining`=WIN, `window_valid`=0, state EDGE_FILL, pulse `shift_done`.
  - `shift_direc`=00: window unchanged, state unchanged, pulse `err`.
- Ignored requests, each pulsing `err` with no state or window change:
  - `start_shift` in FULL_FILL or EDGE_FILL
  - `start_read` in READY
- Simultaneous `start_shift` and `start_read`:
  - READY: the shift is executed and the read is dropped; `err` pulses.
  - Fill states: the read is accepted and the shift is dropped; `err` pulses.
- `rst` asserted at any point, including mid-fill, returns to the reset values. No partial window survives.
- `fill_remaining` never underflows. Reads beyond the need are impossible because the state has already moved to READY.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- Accept and update happen on the same clock edge. A request sampled at edge N produces:
  - `window` and `fill_remaining` updated after edge N
  - `read_done`/`shift_done`/`err` high for exactly the cycle after edge N
- Back-to-back reads are accepted every cycle:
  - FULL_FILL: WIN*WIN consecutive cycles minimum.
  - EDGE_FILL: WIN cycles minimum.
- `window_valid` rises in the same cycle as the `read_done` of the last pixel.
- `window_valid` falls in the same cycle as `shift_done`.
- A shift may be issued in the cycle immediately after `window_valid` rises.
- Pulses are never stretched. A request held high for k cycles is evaluated k times. Example: held `start_read` in EDGE_FILL consumes up to WIN pixels, then pulses `err` each further cycle.

## Test plan
All scenarios use WIN=3, DATA_W=8.
- Reset, then 9 consecutive reads of 1..9 -> `window` rows {1,2,3},{4,5,6},{7,8,9}; `window_valid`=1 on the 9th `read_done`; `fill_remaining`=0.
- From that state, shift 01, then reads 10,11,12 -> `shift_done` pulse; rows {2,3,0},{5,6,0},{8,9,0} with valid=0; final rows {2,3,10},{5,6,11},{8,9,12}, valid=1.
- From the full 1..9 window, shift 11, then reads 0,0,0 -> final rows {0,0,0},{1,2,3},{4,5,6}, valid=1. Zero pixels are accepted with no extra read needed.
- Illegal cases:
  - `start_shift` during FULL_FILL after 4 reads -> `err` pulse; `fill_remaining` stays 5.
  - `shift_direc`=00 in READY -> `err`, window unchanged.
  - `start_read` in READY -> `err`.
- Simultaneous `start_shift`=1 (10) and `start_read`=1 in READY with rows 1..9 -> rows {0,1,2},{0,4,5},{0,7,8}; `shift_done`=1 and `err`=1; `read_done`=0.
- `rst` after 2 of 3 EDGE_FILL reads -> next cycle: `window`=0, valid=0, `fill_remaining`=9, all pulses low.
